// File: rtl/decode_unit.sv
// Instruction decode/issue sequencer: fetches 64-bit words, splits them into fields and
// hands operations to the execution side. Define DECODE_ILLEGAL_TRAP_EN to trap illegal opcodes.
module decode_unit #(
    parameter int unsigned INSTR_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   fetch_en_o,
    input  logic                   fetch_done_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    output logic                   issue_valid_o,
    input  logic                   issue_ready_i,
    output logic [4:0]             opcode_o,
    output logic [4:0]             dest_o,
    output logic [4:0]             src1_o,
    output logic [4:0]             src2_o,
    output logic [19:0]            len_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [15:0]            instr_cnt_o,
    output logic                   busy_o,
    output logic                   halted_o,
    output logic                   error_o
);

    localparam logic [4:0] OpNop   = 5'h00;
    localparam logic [4:0] OpLoadV = 5'h01;
    localparam logic [4:0] OpLoadM = 5'h02;
    localparam logic [4:0] OpStore = 5'h03;
    localparam logic [4:0] OpGemv  = 5'h04;
    localparam logic [4:0] OpRelu  = 5'h05;
    localparam logic [4:0] OpHalt  = 5'h1F;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDecode,
        StIssue,
        StHalted,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [4:0]             opcode_q, opcode_d;
    logic [4:0]             dest_q, dest_d;
    logic [4:0]             src1_q, src1_d;
    logic [4:0]             src2_q, src2_d;
    logic [19:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]            instr_cnt_q, instr_cnt_d;

    logic [4:0] dec_op;
    logic       dec_len_zero;

    assign dec_op       = instr_q[63:59];
    assign dec_len_zero = (instr_q[43:24] == 20'h0);

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        opcode_d    = opcode_q;
        dest_d      = dest_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        len_d       = len_q;
        addr_d      = addr_q;
        instr_cnt_d = instr_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StReq;
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                if (fetch_done_i) begin
                    instr_d = instr_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                opcode_d = instr_q[63:59];
                dest_d   = instr_q[58:54];
                src1_d   = instr_q[53:49];
                src2_d   = instr_q[48:44];
                len_d    = instr_q[43:24];
                addr_d   = ADDR_WIDTH'(instr_q[23:0]);
                // Zero-length memory/compute ops retire without reaching the execution side
                case (dec_op)
                    OpLoadV, OpLoadM, OpStore, OpGemv: begin
                        if (dec_len_zero) begin
                            instr_cnt_d = instr_cnt_q + 16'd1;
                            state_d     = StReq;
                        end else begin
                            state_d = StIssue;
                        end
                    end
                    OpRelu: begin
                        state_d = StIssue;
                    end
                    OpNop: begin
                        instr_cnt_d = instr_cnt_q + 16'd1;
                        state_d     = StReq;
                    end
                    OpHalt: begin
                        instr_cnt_d = instr_cnt_q + 16'd1;
                        state_d     = StHalted;
                    end
                    default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                        state_d = StError;
`else
                        instr_cnt_d = instr_cnt_q + 16'd1;
                        state_d     = StReq;
`endif
                    end
                endcase
            end
            StIssue: begin
                if (issue_ready_i) begin
                    instr_cnt_d = instr_cnt_q + 16'd1;
                    state_d     = StReq;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            instr_q     <= '0;
            opcode_q    <= '0;
            dest_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            opcode_q    <= opcode_d;
            dest_q      <= dest_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign fetch_en_o    = (state_q == StReq);
    assign issue_valid_o = (state_q == StIssue);
    assign busy_o        = (state_q == StReq) || (state_q == StWait) ||
                           (state_q == StDecode) || (state_q == StIssue);
    assign halted_o      = (state_q == StHalted);
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign error_o       = (state_q == StError);
`else
    assign error_o       = 1'b0;
`endif

    assign opcode_o    = opcode_q;
    assign dest_o      = dest_q;
    assign src1_o      = src1_q;
    assign src2_o      = src2_q;
    assign len_o       = len_q;
    assign addr_o      = addr_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed programs, issue scoreboard drained by a monitor.
module tb_decode_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        fetch_en_o;
    logic        fetch_done_i;
    logic [63:0] instr_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [4:0]  opcode_o;
    logic [4:0]  dest_o;
    logic [4:0]  src1_o;
    logic [4:0]  src2_o;
    logic [19:0] len_o;
    logic [23:0] addr_o;
    logic [15:0] instr_cnt_o;
    logic        busy_o;
    logic        halted_o;
    logic        error_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb_q[$];
    logic        no_issue_win = 1'b0;

    decode_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .fetch_en_o   (fetch_en_o),
        .fetch_done_i (fetch_done_i),
        .instr_i      (instr_i),
        .issue_valid_o(issue_valid_o),
        .issue_ready_i(issue_ready_i),
        .opcode_o     (opcode_o),
        .dest_o       (dest_o),
        .src1_o       (src1_o),
        .src2_o       (src2_o),
        .len_o        (len_o),
        .addr_o       (addr_o),
        .instr_cnt_o  (instr_cnt_o),
        .busy_o       (busy_o),
        .halted_o     (halted_o),
        .error_o      (error_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [4:0] dest,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [19:0] len, input logic [23:0] addr);
        return {op, dest, s1, s2, len, addr};
    endfunction

    // Monitor: pops the scoreboard on each issue handshake
    always @(negedge clk) begin
        if (!rst && no_issue_win) chk("no_issue", {63'd0, issue_valid_o}, 64'd0);
        if (!rst && issue_valid_o && issue_ready_i) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got issue op %0h want none", opcode_o);
            end else begin
                chk("sb_fields", {opcode_o, dest_o, src1_o, src2_o, len_o, addr_o},
                    sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        start_i       = 1'b0;
        fetch_done_i  = 1'b0;
        issue_ready_i = 1'b0;
        instr_i       = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Called in REQ; returns with the DUT in DECODE
    task automatic feed(input logic [63:0] w, input int gap);
        tick();
        repeat (gap) tick();
        fetch_done_i = 1'b1;
        instr_i      = w;
        tick();
        fetch_done_i = 1'b0;
        instr_i      = '0;
    endtask

    logic [63:0] w_gemv;
    logic [63:0] w_relu;
    logic        saw_fetch;

    initial begin
        w_gemv = mk(5'h04, 5'd3, 5'd1, 5'd2, 20'h00100, 24'h000400);
        w_relu = mk(5'h05, 5'd7, 5'd6, 5'd0, 20'h00040, 24'h001230);

        // Reset state
        do_reset();
        chk("rst_flags", {59'd0, fetch_en_o, issue_valid_o, busy_o, halted_o, error_o}, 64'd0);
        chk("rst_cnt", {48'd0, instr_cnt_o}, 64'd0);
        chk("rst_fields", {opcode_o, dest_o, src1_o, src2_o, len_o, addr_o}, 64'd0);

        // fetch_done in first cycle after release is ignored
        fetch_done_i = 1'b1;
        instr_i      = w_gemv;
        tick();
        fetch_done_i = 1'b0;
        tick();
        chk("post_rst_done_ignored", {62'd0, busy_o, fetch_en_o}, 64'd0);

        // GEMV issue, latency and hold
        do_start();
        chk("start_fetch_en", {63'd0, fetch_en_o}, 64'd1);
        chk("start_busy", {63'd0, busy_o}, 64'd1);
        tick();
        chk("fetch_en_one_cycle", {63'd0, fetch_en_o}, 64'd0);
        fetch_done_i = 1'b1;
        instr_i      = w_gemv;
        tick();
        fetch_done_i = 1'b0;
        sb_q.push_back(w_gemv);
        chk("lat_decode_no_valid", {63'd0, issue_valid_o}, 64'd0);
        tick();
        chk("lat_issue_valid", {63'd0, issue_valid_o}, 64'd1);
        chk("gemv_opcode", {59'd0, opcode_o}, 64'h04);
        chk("gemv_len", {44'd0, len_o}, 64'h00100);
        chk("gemv_addr", {40'd0, addr_o}, 64'h000400);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_stable", {issue_valid_o, opcode_o, dest_o, src1_o, src2_o, len_o, addr_o},
                {1'b1, w_gemv});
        end
        chk("hold_cnt", {48'd0, instr_cnt_o}, 64'd0);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        chk("post_hs_fetch_en", {63'd0, fetch_en_o}, 64'd1);
        chk("post_hs_cnt", {48'd0, instr_cnt_o}, 64'd1);

        // NOP, LOAD_V len=0, HALT: nothing issued
        do_reset();
        no_issue_win = 1'b1;
        do_start();
        feed(mk(5'h00, 5'd1, 5'd2, 5'd3, 20'h00010, 24'h000010), 0);
        tick();
        chk("nop_refetch", {63'd0, fetch_en_o}, 64'd1);
        feed(mk(5'h01, 5'd4, 5'd0, 5'd0, 20'h00000, 24'h000800), 0);
        tick();
        chk("len0_refetch", {63'd0, fetch_en_o}, 64'd1);
        chk("len0_cnt", {48'd0, instr_cnt_o}, 64'd2);
        feed(mk(5'h1F, 5'd0, 5'd0, 5'd0, 20'h00000, 24'h000000), 0);
        tick();
        chk("halt_cnt", {48'd0, instr_cnt_o}, 64'd3);
        chk("halt_flags", {61'd0, halted_o, busy_o, fetch_en_o}, 64'b100);
        do_start();
        tick();
        tick();
        chk("halt_sticky", {61'd0, halted_o, busy_o, fetch_en_o}, 64'b100);
        no_issue_win = 1'b0;

        // Illegal opcode 0x10
        do_reset();
        do_start();
        feed(mk(5'h10, 5'd1, 5'd1, 5'd1, 20'h00004, 24'h000004), 0);
        tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("illegal_error", {63'd0, error_o}, 64'd1);
        chk("illegal_cnt", {48'd0, instr_cnt_o}, 64'd0);
        saw_fetch = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (fetch_en_o || issue_valid_o) saw_fetch = 1'b1;
            tick();
        end
        chk("illegal_no_fetch", {63'd0, saw_fetch}, 64'd0);
        chk("illegal_error_sticky", {62'd0, error_o, busy_o}, 64'b10);
`else
        chk("illegal_error", {63'd0, error_o}, 64'd0);
        chk("illegal_cnt", {48'd0, instr_cnt_o}, 64'd1);
        chk("illegal_refetch", {63'd0, fetch_en_o}, 64'd1);
`endif

        // Reset in the middle of ISSUE
        do_reset();
        do_start();
        feed(mk(5'h00, 5'd0, 5'd0, 5'd0, 20'h00000, 24'h000000), 0);
        tick();
        feed(mk(5'h03, 5'd9, 5'd8, 5'd5, 20'h00002, 24'h0000F0), 0);
        tick();
        chk("mid_issue_valid", {63'd0, issue_valid_o}, 64'd1);
        chk("mid_issue_cnt", {48'd0, instr_cnt_o}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_flags", {59'd0, fetch_en_o, issue_valid_o, busy_o, halted_o, error_o},
            64'd0);
        chk("async_rst_cnt_fields", {instr_cnt_o, opcode_o, len_o, addr_o}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        do_start();
        chk("restart_fetch_en", {63'd0, fetch_en_o}, 64'd1);
        feed(w_relu, 0);
        sb_q.push_back(w_relu);
        tick();
        chk("relu_valid", {63'd0, issue_valid_o}, 64'd1);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        chk("restart_cnt", {48'd0, instr_cnt_o}, 64'd1);

        // Counter wrap from a preloaded count
        do_reset();
        do_start();
        force dut.instr_cnt_q = 16'hFFFE;
        #1 release dut.instr_cnt_q;
        feed(mk(5'h00, 5'd0, 5'd0, 5'd0, 20'h00000, 24'h000000), 0);
        tick();
        chk("wrap_ffff", {48'd0, instr_cnt_o}, 64'hFFFF);
        feed(mk(5'h00, 5'd0, 5'd0, 5'd0, 20'h00000, 24'h000000), 0);
        tick();
        chk("wrap_zero", {48'd0, instr_cnt_o}, 64'h0000);
        chk("wrap_no_error", {62'd0, error_o, fetch_en_o}, 64'b01);

        tick();
        chk("sb_drained", {32'd0, sb_q.size()}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
